// File: rtl/sopc_verin_cpu_debug_ocimem.sv
// Nios II on-chip debug memory: JTAG monitor access to a debug RAM,
// arbitrated against CPU Avalon accesses, plus monitor handshake flags.
module sopc_verin_cpu_debug_ocimem #(
  parameter int RAM_AW = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [RAM_AW:0]   address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  input  logic              debugaccess,
  output logic [31:0]       readdata,
  output logic              waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              monitor_go
);

  typedef enum logic [2:0] {
    IDLE, J_RD, J_CAP, J_WR, C_ACC, C_DONE
  } state_t;

  state_t state_q, state_d;

  logic [RAM_AW-1:0] mon_areg;
  logic              pend_rd;
  logic              pend_wr;
  logic [31:0]       mem [2**RAM_AW];
  logic [31:0]       ram_q;
  logic [31:0]       ctl_q;
  logic              rd_hi_q;

  logic              take_any;
  logic              cpu_ram;
  logic              cpu_ctl;
  logic [RAM_AW-1:0] ram_addr;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wd;
  logic              unused_jdo;

  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  assign take_any = take_action_ocimem_a
                  | take_no_action_ocimem_a
                  | take_action_ocimem_b;

  assign cpu_ram = ~address[RAM_AW];
  assign cpu_ctl = address[RAM_AW]
                 & (address[RAM_AW-1:0] == '0);

  assign ram_addr = (state_q == C_ACC)
                  ? address[RAM_AW-1:0] : mon_areg;

  // Gated by reset_n so a write can never land while reset is asserted.
  assign ram_we = reset_n
                & ((state_q == J_WR)
                 | ((state_q == C_ACC) & write & cpu_ram));

  assign ram_be = (state_q == J_WR) ? 4'hF : byteenable;
  assign ram_wd = (state_q == J_WR) ? MonDReg : writedata;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_be[i])
          mem[ram_addr][8*i +: 8] <= ram_wd[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ram_q <= '0;
    else          ram_q <= mem[ram_addr];
  end

  assign readdata = (state_q != C_DONE) ? 32'h0
                  : (rd_hi_q ? ctl_q : ram_q);

  // A take pulse in IDLE holds off the CPU so the JTAG command
  // it creates is serviced first.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pend_rd)
          state_d = J_RD;
        else if (pend_wr)
          state_d = J_WR;
        else if (take_any)
          state_d = IDLE;
        else if (read | write)
          state_d = C_ACC;
      end
      J_RD:    state_d = J_CAP;
      J_CAP:   state_d = IDLE;
      J_WR:    state_d = IDLE;
      C_ACC:   state_d = C_DONE;
      C_DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      waitrequest   <= 1'b1;
      MonDReg       <= '0;
      mon_areg      <= '0;
      pend_rd       <= 1'b0;
      pend_wr       <= 1'b0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
      monitor_go    <= 1'b0;
      ctl_q         <= '0;
      rd_hi_q       <= 1'b0;
    end else begin
      waitrequest <= (state_d != C_DONE);

      unique case (state_q)
        J_RD:  pend_rd <= 1'b0;
        J_CAP: MonDReg <= ram_q;
        J_WR: begin
          pend_wr  <= 1'b0;
          mon_areg <= mon_areg + RAM_AW'(1);
        end
        C_ACC: begin
          rd_hi_q <= address[RAM_AW];
          ctl_q   <= cpu_ctl
                   ? {29'b0, monitor_go,
                      monitor_error, monitor_ready}
                   : 32'h0;
          if (write & cpu_ctl & debugaccess) begin
            monitor_ready <= monitor_ready | writedata[0];
            monitor_error <= monitor_error | writedata[1];
            monitor_go    <= 1'b0;
          end
        end
        default: ;
      endcase

      // Newest JTAG command overrides whatever the slot held.
      if (take_action_ocimem_a) begin
        mon_areg <= jdo[26 +: RAM_AW];
        if (jdo[35]) begin
          pend_rd <= 1'b1;
          pend_wr <= 1'b0;
        end
        if (jdo[25]) begin
          monitor_ready <= 1'b0;
          monitor_error <= 1'b0;
        end
        if (jdo[24])
          monitor_go <= 1'b1;
      end

      if (take_no_action_ocimem_a) begin
        mon_areg <= mon_areg + RAM_AW'(1);
        pend_rd  <= 1'b1;
        pend_wr  <= 1'b0;
      end

      if (take_action_ocimem_b) begin
        MonDReg <= jdo[34:3];
        pend_wr <= 1'b1;
        pend_rd <= 1'b0;
      end
    end
  end

endmodule
